// File: rtl/wb_arb_pkg.sv
// Shared types for the Wishbone classic arbiter: FSM states,
// the controller-count ceiling and a one-hot to index helper.
package wb_arb_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam int MAX_CTRL = 16;
  localparam int IDX_W    = $clog2(MAX_CTRL);

  // Input must be one-hot or zero; zero maps to index 0.
  function automatic logic [IDX_W-1:0] oh2idx(
    input logic [MAX_CTRL-1:0] oh
  );
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_CTRL; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: first requester above ptr_i, else lowest.
// Ports: req_i request vector, ptr_i last-granted index, gnt_o one-hot pick.
module wb_rr_picker
  import wb_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    // Pass 1: requesters strictly above the pointer.
    for (int j = 0; j < N; j++) begin
      if (!found && req_i[j] && (j > int'(ptr_i))) begin
        gnt_o[j] = 1'b1;
        found    = 1'b1;
      end
    end
    // Pass 2: wrap around to the lowest requester.
    for (int j = 0; j < N; j++) begin
      if (!found && req_i[j]) begin
        gnt_o[j] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_classic_arbiter.sv
// Round-robin Wishbone classic arbiter: NUM_CTRL controllers share one device.
// Ports: clk_i/rst_i (sync, active-high); c_* controller side, vectors
// indexed by controller, c_dat_i packed ctrl k at [k*DAT_WIDTH +: DAT_WIDTH];
// d_* device side; gnt_o registered one-hot grant, zero when idle.
// Optional WB_ARB_TIMEOUT_EN: forced err after TIMEOUT stalled wait states.
module wb_classic_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DAT_WIDTH = 8,
  parameter int NUM_CTRL  = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_CTRL-1:0]           c_cyc_i,
  input  logic [NUM_CTRL-1:0]           c_stb_i,
  input  logic [NUM_CTRL-1:0]           c_we_i,
  input  logic [NUM_CTRL*DAT_WIDTH-1:0] c_dat_i,
  output logic [NUM_CTRL-1:0]           c_ack_o,
  output logic [NUM_CTRL-1:0]           c_err_o,
  output logic [NUM_CTRL-1:0]           c_rty_o,
  output logic [DAT_WIDTH-1:0]          c_dat_o,
  output logic                          d_cyc_o,
  output logic                          d_stb_o,
  output logic                          d_we_o,
  output logic [DAT_WIDTH-1:0]          d_dat_o,
  input  logic                          d_ack_i,
  input  logic                          d_err_i,
  input  logic                          d_rty_i,
  input  logic [DAT_WIDTH-1:0]          d_dat_i,
  output logic [NUM_CTRL-1:0]           gnt_o
);

  state_t               state_q, state_d;
  logic [NUM_CTRL-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_CTRL-1:0]  pick;
  logic [IDX_W-1:0]     g_idx;
  logic                 busy;
  logic                 g_cyc, g_stb, g_we;
  logic [DAT_WIDTH-1:0] g_dat;
  logic                 to_fire;
  logic                 rsp_ok;

  wb_rr_picker #(
    .N(NUM_CTRL)
  ) u_picker (
    .req_i(c_cyc_i),
    .ptr_i(ptr_q),
    .gnt_o(pick)
  );

  assign busy  = (state_q == BUSY);
  assign g_idx = oh2idx(MAX_CTRL'(gnt_q));
  assign g_cyc = |(gnt_q & c_cyc_i);
  assign g_stb = |(gnt_q & c_stb_i);
  assign g_we  = |(gnt_q & c_we_i);

  always_comb begin
    g_dat = '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (gnt_q[k]) g_dat = g_dat | c_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
    end
  end

  // A timeout cycle hides the device, so any response then is dropped.
  assign rsp_ok = busy & g_cyc & g_stb & ~to_fire;

  assign d_cyc_o = busy & g_cyc & ~to_fire;
  assign d_stb_o = busy & g_stb & ~to_fire;
  assign d_we_o  = busy & g_we;
  assign d_dat_o = busy ? g_dat : '0;

  assign c_ack_o = gnt_q & {NUM_CTRL{rsp_ok & d_ack_i}};
  assign c_err_o = gnt_q & {NUM_CTRL{(rsp_ok & d_err_i) | to_fire}};
  assign c_rty_o = gnt_q & {NUM_CTRL{rsp_ok & d_rty_i}};
  assign c_dat_o = d_dat_i;
  assign gnt_o   = gnt_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|c_cyc_i) begin
          gnt_d   = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!g_cyc) begin
          ptr_d   = g_idx;
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= IDX_W'(NUM_CTRL - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          any_rsp;

  assign any_rsp = d_ack_i | d_err_i | d_rty_i;
  assign to_fire = busy && (cnt_q == CW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (!busy || to_fire || any_rsp) begin
      cnt_d = '0;
    end else if (g_cyc && g_stb) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign to_fire        = 1'b0;
`endif

endmodule

// File: tb/tb_wb_classic_arbiter.sv
// Self-checking bench for wb_classic_arbiter (NUM_CTRL=4, DAT_WIDTH=8).
// Directed table, corner sequences and random traffic vs a reference model.
module tb_wb_classic_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 4;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] c_cyc, c_stb, c_we;
  logic [N*W-1:0] c_dat;
  logic [N-1:0] c_ack, c_err, c_rty;
  logic [W-1:0] c_dat_o;
  logic         d_cyc, d_stb, d_we;
  logic [W-1:0] d_dat_o;
  logic         d_ack, d_err, d_rty;
  logic [W-1:0] d_dat;
  logic [N-1:0] gnt;

  always #5 clk = ~clk;

  wb_classic_arbiter #(
    .DAT_WIDTH(W),
    .NUM_CTRL(N),
    .TIMEOUT(TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .c_cyc_i(c_cyc),
    .c_stb_i(c_stb),
    .c_we_i(c_we),
    .c_dat_i(c_dat),
    .c_ack_o(c_ack),
    .c_err_o(c_err),
    .c_rty_o(c_rty),
    .c_dat_o(c_dat_o),
    .d_cyc_o(d_cyc),
    .d_stb_o(d_stb),
    .d_we_o(d_we),
    .d_dat_o(d_dat_o),
    .d_ack_i(d_ack),
    .d_err_i(d_err),
    .d_rty_i(d_rty),
    .d_dat_i(d_dat),
    .gnt_o(gnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: granted controller (-1 = none), last winner, stall count.
  int mg, mlast, mcnt;
  bit mvalid = 1'b0;

  logic [N-1:0] seen_gnt, seen_ack, seen_err;
  logic         seen_dcyc;
  int           glog[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [34:0] model_out();
    logic         busy, fire, gc, gs, gw, fwd;
    logic [N-1:0] eg;
    logic [W-1:0] dd;
    busy = (mg >= 0);
    fire = TO_EN && busy && (mcnt == TO);
    gc = 1'b0; gs = 1'b0; gw = 1'b0; dd = '0; eg = '0;
    if (busy) begin
      gc = c_cyc[mg];
      gs = c_stb[mg];
      gw = c_we[mg];
      dd = c_dat[mg*W +: W];
      eg = N'(1 << mg);
    end
    fwd = gc && gs && !fire;
    return {eg, gc & ~fire, gs & ~fire, gw, dd,
            (fwd && d_ack) ? eg : 4'h0,
            ((fwd && d_err) || fire) ? eg : 4'h0,
            (fwd && d_rty) ? eg : 4'h0,
            d_dat};
  endfunction

  task automatic model_edge();
    bit fire, found;
    int idx;
    if (rst) begin
      mg = -1; mlast = N - 1; mcnt = 0; mvalid = 1'b1;
    end else if (mvalid) begin
      fire = TO_EN && (mg >= 0) && (mcnt == TO);
      if (mg < 0 || fire || d_ack || d_err || d_rty) mcnt = 0;
      else if (c_cyc[mg] && c_stb[mg]) mcnt++;
      if (mg < 0) begin
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
          idx = (mlast + i) % N;
          if (!found && c_cyc[idx]) begin
            mg = idx;
            found = 1'b1;
          end
        end
      end else if (!c_cyc[mg]) begin
        mlast = mg;
        mg = -1;
      end
    end
  endtask

  // Inputs are set at a negedge; outputs checked 1ns later; model steps
  // on the posedge; returns at the following negedge.
  task automatic step();
    #1;
    if (mvalid)
      chk("cycle", 64'({gnt, d_cyc, d_stb, d_we, d_dat_o, c_ack, c_err,
                        c_rty, c_dat_o}), 64'(model_out()));
    seen_gnt  = gnt;
    seen_ack  = c_ack;
    seen_err  = c_err;
    seen_dcyc = d_cyc;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_in();
    c_cyc = '0; c_stb = '0; c_we = '0;
    d_ack = 1'b0; d_err = 1'b0; d_rty = 1'b0;
  endtask

  task automatic drain();
    idle_in();
    step();
    step();
  endtask

  // Controllers in want_i request; device acks every strobe; each drops
  // cyc after its ack. reraise0: ctrl0 requests again once.
  task automatic serve(input logic [N-1:0] want_i, input bit reraise0,
                       input int ngr);
    logic [N-1:0] want, prevg;
    bit wait0, used0;
    want = want_i; prevg = '0; wait0 = 1'b0; used0 = 1'b0;
    glog.delete();
    for (int t = 0; t < 80 && glog.size() < ngr; t++) begin
      c_cyc = want; c_stb = want; c_we = '0;
      c_dat = $urandom; d_dat = W'($urandom); d_ack = 1'b1;
      step();
      if (seen_gnt != 0 && seen_gnt != prevg)
        for (int k = 0; k < N; k++) if (seen_gnt[k]) glog.push_back(k);
      prevg = seen_gnt;
      if (wait0) begin
        want[0] = 1'b1;
        wait0 = 1'b0;
      end
      for (int k = 0; k < N; k++) begin
        if (seen_ack[k]) begin
          want[k] = 1'b0;
          if (k == 0 && reraise0 && !used0) begin
            wait0 = 1'b1;
            used0 = 1'b1;
          end
        end
      end
    end
    chk("serve_ngrants", 64'(glog.size()), 64'(ngr));
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] cyc;
    logic [N*W-1:0] dat;
    logic         dack;
    logic [N-1:0] egnt;
    logic         edcyc;
    logic [W-1:0] eddat;
    logic [N-1:0] ecack;
  } vec_t;

  vec_t tbl[7];
  int   nack, nerr;
  logic [N-1:0] want;

  initial begin
    rst = 1'b1; c_dat = '0; d_dat = '0;
    idle_in();
    // ctrl2 writes A5, device acks after two wait states.
    tbl[0] = '{1'b1, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000};
    tbl[1] = '{1'b0, 4'b0100, 32'h00A50000, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000};
    tbl[2] = '{1'b0, 4'b0100, 32'h00A50000, 1'b0, 4'b0100, 1'b1, 8'hA5, 4'b0000};
    tbl[3] = '{1'b0, 4'b0100, 32'h00A50000, 1'b0, 4'b0100, 1'b1, 8'hA5, 4'b0000};
    tbl[4] = '{1'b0, 4'b0100, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 8'hA5, 4'b0100};
    tbl[5] = '{1'b0, 4'b0000, 32'h00A50000, 1'b0, 4'b0100, 1'b0, 8'hA5, 4'b0000};
    tbl[6] = '{1'b0, 4'b0000, 32'h0,        1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000};

    @(negedge clk);
    step();
    step();

    for (int i = 0; i < 7; i++) begin
      rst = tbl[i].rst;
      c_cyc = tbl[i].cyc; c_stb = tbl[i].cyc; c_we = tbl[i].cyc;
      c_dat = tbl[i].dat; d_ack = tbl[i].dack; d_dat = 8'h3C;
      #1;
      chk($sformatf("tbl%0d_gnt", i), 64'(gnt), 64'(tbl[i].egnt));
      chk($sformatf("tbl%0d_dcyc", i), 64'(d_cyc), 64'(tbl[i].edcyc));
      chk($sformatf("tbl%0d_ddat", i), 64'(d_dat_o), 64'(tbl[i].eddat));
      chk($sformatf("tbl%0d_cack", i), 64'(c_ack), 64'(tbl[i].ecack));
      step();
    end

    // Contention from pointer=3 state: expect 0,1,2,3,0.
    rst = 1'b1; idle_in(); step(); rst = 1'b0;
    serve(4'b1111, 1'b1, 5);
    for (int i = 0; i < 5; i++)
      chk($sformatf("contend_%0d", i),
          64'(i < glog.size() ? glog[i] : -1), 64'((i == 4) ? 0 : i));
    drain();

    // Wrap: make ctrl3 the last winner, then ctrl0 and ctrl3 race.
    serve(4'b1000, 1'b0, 1);
    drain();
    serve(4'b1001, 1'b0, 2);
    chk("wrap_first", 64'(glog.size() > 0 ? glog[0] : -1), 64'(0));
    chk("wrap_second", 64'(glog.size() > 1 ? glog[1] : -1), 64'(3));
    drain();

    // Lock: ctrl1 holds cyc across three acks while ctrl0 waits.
    c_cyc = 4'b0010; c_stb = 4'b0010; d_ack = 1'b0;
    step();
    c_cyc = 4'b0011; c_stb = 4'b0011;
    nack = 0;
    for (int i = 0; i < 6; i++) begin
      d_ack = (i % 2 == 1);
      step();
      chk("lock_gnt", 64'(seen_gnt), 64'(4'b0010));
      chk("lock_ack0", 64'(seen_ack[0]), 64'(0));
      if (seen_ack[1]) nack++;
    end
    chk("lock_nack", 64'(nack), 64'(3));
    c_cyc = 4'b0001; c_stb = 4'b0001; d_ack = 1'b0;
    step();
    chk("lock_hold", 64'(seen_gnt), 64'(4'b0010));
    step();
    chk("lock_gap", 64'(seen_gnt), 64'(4'b0000));
    step();
    chk("lock_next", 64'(seen_gnt), 64'(4'b0001));
    drain();

    // Reset mid-cycle while ctrl3 awaits ack.
    c_cyc = 4'b1000; c_stb = 4'b1000;
    step();
    step();
    chk("rstmid_gnt", 64'(seen_gnt), 64'(4'b1000));
    rst = 1'b1;
    step();
    rst = 1'b0; c_cyc = 4'b1001; c_stb = 4'b1001; d_ack = 1'b1;
    step();
    chk("rstmid_gnt0", 64'(seen_gnt), 64'(0));
    chk("rstmid_dcyc", 64'(seen_dcyc), 64'(0));
    chk("rstmid_ack", 64'(seen_ack), 64'(0));
    d_ack = 1'b0;
    step();
    chk("rstmid_prio", 64'(seen_gnt), 64'(4'b0001));
    drain();

    // Stalled device: forced err only in the timeout build.
    c_cyc = 4'b0100; c_stb = 4'b0100; d_ack = 1'b0;
    step();
    nerr = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (seen_err[2]) nerr++;
    end
    chk("timeout_errs", 64'(nerr), 64'(TO_EN ? 1 : 0));
    drain();

    // Random traffic against the model.
    want = '0;
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int k = 0; k < N; k++) begin
        if (want[k]) want[k] = ($urandom_range(0, 4) != 0);
        else         want[k] = ($urandom_range(0, 3) == 0);
      end
      c_cyc = want;
      c_stb = want & N'($urandom);
      c_we  = N'($urandom);
      c_dat = $urandom;
      d_dat = W'($urandom);
      d_ack = ($urandom_range(0, 2) == 0);
      d_err = ($urandom_range(0, 9) == 0);
      d_rty = ($urandom_range(0, 9) == 0);
      step();
    end
    rst = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
